// File: rtl/mcu_local_axil_stream_reader_if.sv
// AXI-Lite read channel plus AXI-Stream output of the local read engine.
// The master modport is the engine side; the slave modport faces memory and the sink.
interface mcu_local_axil_stream_reader_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] m_axil_araddr;
    logic [2:0]            m_axil_arprot;
    logic                  m_axil_arvalid;
    logic                  m_axil_arready;
    logic [DATA_WIDTH-1:0] m_axil_rdata;
    logic [1:0]            m_axil_rresp;
    logic                  m_axil_rvalid;
    logic                  m_axil_rready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        output m_axil_araddr, m_axil_arprot, m_axil_arvalid,
        input  m_axil_arready,
        input  m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        output m_axil_rready,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport slave (
        input  m_axil_araddr, m_axil_arprot, m_axil_arvalid,
        output m_axil_arready,
        output m_axil_rdata, m_axil_rresp, m_axil_rvalid,
        input  m_axil_rready,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/mcu_local_axil_stream_reader.sv
// Local read engine: fetches an N x M block of AXI-Lite words and streams each word R times,
// keeping reads in flight plus buffered words within MAX_OUTSTANDING so rready never stalls.
module mcu_local_axil_stream_reader #(
    parameter int DATA_WIDTH       = 16,
    parameter int ADDR_WIDTH       = 32,
    parameter int INTER_ITER_WIDTH = 32,
    parameter int INTRA_ITER_WIDTH = 32,
    parameter int MAX_OUTSTANDING  = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          clear,
    input  logic [ADDR_WIDTH-1:0]         base_addr,
    input  logic [ADDR_WIDTH-1:0]         word_count,
    input  logic [INTER_ITER_WIDTH-1:0]   iter_count,
    input  logic [INTRA_ITER_WIDTH-1:0]   repeat_count,
    mcu_local_axil_stream_reader_if.master bus,
    output logic                          busy,
    output logic                          done,
    output logic                          error
);
    localparam int SHIFT = $clog2(DATA_WIDTH / 8);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] CREDIT = (CNT_W + 1)'(MAX_OUTSTANDING);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, DONE, ERR} state_t;
    state_t state, state_nx;

    logic [ADDR_WIDTH-1:0]       base_r, words_r, word_idx, out_word, next_addr;
    logic [INTER_ITER_WIDTH-1:0] iters_r, iter_idx, out_iter;
    logic [INTRA_ITER_WIDTH-1:0] reps_r, rep_cnt;
    logic [CNT_W-1:0]            inflight, fifo_count;
    logic [PTR_W-1:0]            wr_ptr, rd_ptr;
    logic [DATA_WIDTH-1:0]       mem [MAX_OUTSTANDING];
    logic issue_done, err_flag, ar_hold;
    logic active, accept, zero_cfg, credit_ok, arvalid, ar_hs, r_hs, r_bad;
    logic push, pop, tvalid, t_hs, word_end, last_beat;

    assign active    = (state == RUN) || (state == DRAIN);
    assign accept    = (state == IDLE) && start;
    assign zero_cfg  = (word_count == '0) || (iter_count == '0) || (repeat_count == '0);
    assign credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < CREDIT;
    // A presented address stays up until accepted, even after an error response.
    assign arvalid   = ((state == RUN) && !issue_done && credit_ok) || (active && ar_hold);
    assign ar_hs     = arvalid && bus.m_axil_arready;
    assign r_hs      = bus.m_axil_rvalid && active;
    assign r_bad     = r_hs && (bus.m_axil_rresp != 2'b00);
    assign push      = r_hs && !r_bad && (state == RUN);
    assign tvalid    = (state == RUN) && (fifo_count != '0);
    assign t_hs      = tvalid && bus.m_axis_tready;
    assign word_end  = rep_cnt == reps_r - INTRA_ITER_WIDTH'(1);
    assign last_beat = word_end && (out_word == words_r - ADDR_WIDTH'(1))
                       && (out_iter == iters_r - INTER_ITER_WIDTH'(1));
    assign pop       = t_hs && word_end;
    assign next_addr = base_r + (word_idx << SHIFT);

    assign bus.m_axil_araddr  = arvalid ? next_addr : '0;
    assign bus.m_axil_arprot  = 3'b000;
    assign bus.m_axil_arvalid = arvalid;
    assign bus.m_axil_rready  = active;
    assign bus.m_axis_tvalid  = tvalid;
    assign bus.m_axis_tdata   = tvalid ? mem[rd_ptr] : '0;
    assign bus.m_axis_tlast   = tvalid && last_beat;
    assign busy  = active;
    assign done  = (state == DONE);
    assign error = (state == ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (start) state_nx = zero_cfg ? DRAIN : RUN;
            RUN: begin
                // An error response beats a simultaneous final beat.
                if (r_bad)                  state_nx = DRAIN;
                else if (t_hs && last_beat) state_nx = DONE;
            end
            DRAIN:    if ((inflight == '0) && !arvalid) state_nx = err_flag ? ERR : DONE;
            DONE, ERR: if (clear) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_r <= '0; words_r <= '0; iters_r <= '0; reps_r <= '0;
            word_idx <= '0; iter_idx <= '0; issue_done <= 1'b0;
            err_flag <= 1'b0; ar_hold <= 1'b0; inflight <= '0;
        end else begin
            ar_hold <= arvalid && !bus.m_axil_arready;
            case ({ar_hs, r_hs})
                2'b10:   inflight <= inflight + CNT_W'(1);
                2'b01:   inflight <= inflight - CNT_W'(1);
                default: ;
            endcase
            if (accept) begin
                base_r <= base_addr; words_r <= word_count;
                iters_r <= iter_count; reps_r <= repeat_count;
                word_idx <= '0; iter_idx <= '0; issue_done <= 1'b0;
                err_flag <= zero_cfg;
            end else begin
                if (r_bad) err_flag <= 1'b1;
                if (ar_hs) begin
                    if (word_idx == words_r - ADDR_WIDTH'(1)) begin
                        word_idx <= '0;
                        if (iter_idx == iters_r - INTER_ITER_WIDTH'(1)) issue_done <= 1'b1;
                        else iter_idx <= iter_idx + INTER_ITER_WIDTH'(1);
                    end else begin
                        word_idx <= word_idx + ADDR_WIDTH'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0; rd_ptr <= '0; fifo_count <= '0;
            rep_cnt <= '0; out_word <= '0; out_iter <= '0;
        end else if (accept || r_bad) begin
            wr_ptr <= '0; rd_ptr <= '0; fifo_count <= '0;
            rep_cnt <= '0; out_word <= '0; out_iter <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_W'(1);
                2'b01:   fifo_count <= fifo_count - CNT_W'(1);
                default: ;
            endcase
            if (t_hs) begin
                if (word_end) begin
                    rep_cnt <= '0;
                    if (out_word == words_r - ADDR_WIDTH'(1)) begin
                        out_word <= '0;
                        out_iter <= out_iter + INTER_ITER_WIDTH'(1);
                    end else begin
                        out_word <= out_word + ADDR_WIDTH'(1);
                    end
                end else begin
                    rep_cnt <= rep_cnt + INTRA_ITER_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.m_axil_rdata;
    end
endmodule

// File: tb/tb_mcu_local_axil_stream_reader.sv
// Directed bench for mcu_local_axil_stream_reader: AXI-Lite slave model returning
// rdata = araddr[15:0] + 0x1000, plus a stream/handshake monitor.
`timescale 1ns/1ps
module tb_mcu_local_axil_stream_reader;
    logic        clk = 1'b0;
    logic        rst_n, start, clear;
    logic [31:0] base_addr, word_count, iter_count, repeat_count;
    logic        busy, done, error;

    mcu_local_axil_stream_reader_if #(.DATA_WIDTH(16), .ADDR_WIDTH(32)) bus ();

    mcu_local_axil_stream_reader #(
        .DATA_WIDTH(16), .ADDR_WIDTH(32), .INTER_ITER_WIDTH(32),
        .INTRA_ITER_WIDTH(32), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
        .base_addr(base_addr), .word_count(word_count), .iter_count(iter_count),
        .repeat_count(repeat_count), .bus(bus),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int n;
    bit r_hold, mon_clr;
    int err_at;

    int          ar_total, r_total, max_out, ar_before_r, rready_low, tl_count, resp_n;
    bit          ar_seen;
    logic [31:0] ar_log[$];
    logic [15:0] bd[$];
    bit          bl[$];
    logic [31:0] aq[$];
    logic        s_arhs, s_rhs;
    logic [31:0] s_araddr;

    logic [15:0] exp_rep [9] = '{16'h1010, 16'h1010, 16'h1010, 16'h1012, 16'h1012,
                                 16'h1012, 16'h1014, 16'h1014, 16'h1014};
    logic [15:0] exp_rst [4] = '{16'h1500, 16'h1500, 16'h1502, 16'h1502};

    // Monitor: samples mid-cycle, when DUT outputs and bench inputs are stable.
    always @(negedge clk) begin
        if (!rst_n || mon_clr) begin
            ar_total = 0; r_total = 0; max_out = 0; ar_before_r = 0;
            rready_low = 0; tl_count = 0; ar_seen = 0;
            ar_log.delete(); bd.delete(); bl.delete();
            s_arhs <= 1'b0; s_rhs <= 1'b0; s_araddr <= '0;
        end else begin
            s_arhs   <= bus.m_axil_arvalid && bus.m_axil_arready;
            s_araddr <= bus.m_axil_araddr;
            s_rhs    <= bus.m_axil_rvalid && bus.m_axil_rready;
            if (bus.m_axil_arvalid && bus.m_axil_arready) begin
                ar_log.push_back(bus.m_axil_araddr);
                ar_total++;
            end
            if (r_total == 0) ar_before_r = ar_total;
            if (bus.m_axil_rvalid && bus.m_axil_rready) r_total++;
            if (ar_total - r_total > max_out) max_out = ar_total - r_total;
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                bd.push_back(bus.m_axis_tdata);
                bl.push_back(bus.m_axis_tlast);
                if (bus.m_axis_tlast) tl_count++;
            end
            if (bus.m_axil_arvalid) ar_seen = 1;
            if (busy && !bus.m_axil_rready) rready_low++;
        end
    end

    // AXI-Lite read slave: one response per accepted address, in order.
    always @(posedge clk) begin
        if (!rst_n || mon_clr) begin
            aq.delete();
            resp_n = 0;
            bus.m_axil_rvalid <= 1'b0;
            bus.m_axil_rdata  <= '0;
            bus.m_axil_rresp  <= 2'b00;
        end else begin
            if (s_arhs) aq.push_back(s_araddr);
            if (!bus.m_axil_rvalid || s_rhs) begin
                if (aq.size() != 0 && !r_hold) begin
                    resp_n++;
                    bus.m_axil_rvalid <= 1'b1;
                    bus.m_axil_rdata  <= aq[0][15:0] + 16'h1000;
                    bus.m_axil_rresp  <= (resp_n == err_at) ? 2'b10 : 2'b00;
                    void'(aq.pop_front());
                end else begin
                    bus.m_axil_rvalid <= 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        step();
        mon_clr = 1'b0;
    endtask

    task automatic do_start(input logic [31:0] b, input logic [31:0] nw,
                            input logic [31:0] m, input logic [31:0] r);
        base_addr = b; word_count = nw; iter_count = m; repeat_count = r;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
        step();
    endtask

    task automatic wait_end(input int limit, input string tag);
        int k = 0;
        while (!(done || error) && k < limit) begin
            step();
            k++;
        end
        check({tag, "_timeout"}, k < limit, 1);
    endtask

    function automatic logic [63:0] outs();
        return {9'b0, bus.m_axil_araddr, bus.m_axil_arvalid, bus.m_axil_rready,
                bus.m_axis_tdata, bus.m_axis_tvalid, bus.m_axis_tlast, busy, done, error};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; clear = 1'b0;
        base_addr = '0; word_count = '0; iter_count = '0; repeat_count = '0;
        bus.m_axil_arready = 1'b1; bus.m_axis_tready = 1'b1;
        r_hold = 1'b0; err_at = 0; mon_clr = 1'b0;
        repeat (3) step();
        check("reset_outputs", outs(), 0);
        check("reset_arprot", bus.m_axil_arprot, 0);
        rst_n = 1'b1;
        step();

        // Basic: base 0x100, N=4, M=2, R=1
        clear_mon();
        do_start(32'h100, 4, 2, 1);
        check("basic_busy", busy, 1);
        check("basic_arvalid", bus.m_axil_arvalid, 1);
        check("basic_araddr0", bus.m_axil_araddr, 32'h100);
        wait_end(100, "basic");
        check("basic_done", done, 1);
        check("basic_error", error, 0);
        check("basic_busy_low", busy, 0);
        check("basic_ar_count", ar_log.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("basic_addr%0d", i), (i < ar_log.size()) ? ar_log[i] : 'x,
                  32'h100 + 32'(2 * (i % 4)));
        check("basic_beats", bd.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("basic_data%0d", i), (i < bd.size()) ? bd[i] : 'x,
                  16'h1100 + 16'(2 * (i % 4)));
            check($sformatf("basic_last%0d", i), (i < bl.size()) ? bl[i] : 1'bx, i == 7);
        end
        do_clear();
        check("basic_clear_outs", outs(), 0);

        // Repeat: N=3, M=1, R=3 with tready toggling
        clear_mon();
        do_start(32'h10, 3, 1, 3);
        n = 0;
        while (!done && n < 200) begin
            bus.m_axis_tready = ~bus.m_axis_tready;
            step();
            n++;
        end
        bus.m_axis_tready = 1'b1;
        check("rep_timeout", n < 200, 1);
        check("rep_done", done, 1);
        check("rep_beats", bd.size(), 9);
        for (int i = 0; i < 9; i++) begin
            check($sformatf("rep_data%0d", i), (i < bd.size()) ? bd[i] : 'x, exp_rep[i]);
            check($sformatf("rep_last%0d", i), (i < bl.size()) ? bl[i] : 1'bx, i == 8);
        end
        do_clear();

        // Credit limit: responses withheld for 20 cycles
        clear_mon();
        r_hold = 1'b1;
        do_start(32'h200, 8, 1, 1);
        repeat (20) step();
        check("credit_ar_held", ar_total, 4);
        check("credit_arvalid_off", bus.m_axil_arvalid, 0);
        check("credit_rready", bus.m_axil_rready, 1);
        r_hold = 1'b0;
        wait_end(100, "credit");
        check("credit_done", done, 1);
        check("credit_ar_before_r", ar_before_r, 4);
        check("credit_max_out", max_out, 4);
        check("credit_rready_low", rready_low, 0);
        check("credit_beats", bd.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("credit_data%0d", i), (i < bd.size()) ? bd[i] : 'x,
                  16'h1200 + 16'(2 * i));
        do_clear();

        // Error on second of four outstanding responses
        clear_mon();
        err_at = 2;
        r_hold = 1'b1;
        do_start(32'h300, 4, 1, 1);
        repeat (8) step();
        check("err_ar_count", ar_total, 4);
        r_hold = 1'b0;
        wait_end(100, "err");
        check("err_error", error, 1);
        check("err_done", done, 0);
        check("err_busy", busy, 0);
        check("err_all_resp", r_total, 4);
        check("err_no_tlast", tl_count, 0);
        do_clear();
        err_at = 0;
        check("err_clear_outs", outs(), 0);

        // Zero config: M=0
        clear_mon();
        do_start(32'h0, 4, 0, 1);
        n = 0;
        while (!error && n < 2) begin
            step();
            n++;
        end
        check("zero_error", error, 1);
        check("zero_no_arvalid", ar_seen, 0);
        do_clear();

        // Reset mid-run with three reads in flight
        clear_mon();
        r_hold = 1'b1;
        do_start(32'h400, 8, 1, 1);
        n = 0;
        while (ar_total < 3 && n < 20) begin
            step();
            n++;
        end
        check("rst_inflight3", ar_total, 3);
        rst_n = 1'b0;
        #1;
        check("rst_outputs", outs(), 0);
        step();
        step();
        r_hold = 1'b0;
        rst_n = 1'b1;
        step();
        do_start(32'h500, 2, 1, 2);
        wait_end(100, "rst_rerun");
        check("rst_rerun_done", done, 1);
        check("rst_rerun_beats", bd.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rst_data%0d", i), (i < bd.size()) ? bd[i] : 'x, exp_rst[i]);
            check($sformatf("rst_last%0d", i), (i < bl.size()) ? bl[i] : 1'bx, i == 3);
        end
        check("rst_ar_count", ar_log.size(), 2);
        do_clear();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
